// File: rtl/pattern_sweep_capture_if.sv
// Record stream between pattern_sweep_capture and a response logger.
// One record = (pattern, response bit), transferred on rd_valid && rd_ready.
interface pattern_sweep_capture_if #(
    parameter int N_WIDTH = 3
);
    logic               rd_valid;
    logic [N_WIDTH-1:0] rd_pattern;
    logic               rd_bit;
    logic               rd_ready;

    // Capture stage produces records
    modport master (
        output rd_valid,
        output rd_pattern,
        output rd_bit,
        input  rd_ready
    );

    // Logger consumes records
    modport slave (
        input  rd_valid,
        input  rd_pattern,
        input  rd_bit,
        output rd_ready
    );
endinterface

// File: rtl/pattern_sweep_capture.sv
// pattern_sweep_capture: drives an exhaustive ascending sweep onto a small
// combinational DUT, samples its single-bit output per pattern, builds the
// response vector and a MISR signature, and streams (pattern, bit) records.
// Optional feature macro: GOLDEN_COMPARE_EN (golden_vec input, mismatch and
// mismatch_count outputs).
module pattern_sweep_capture #(
    parameter int                   N_WIDTH       = 3,
    parameter int                   SETTLE_CYCLES = 1,
    parameter int                   SIG_WIDTH     = 16,
    parameter logic [SIG_WIDTH-1:0] POLY          = 16'h1021
) (
    input  logic                      CK,
    input  logic                      reset,
    input  logic                      start,
    output logic [0:N_WIDTH-1]        pattern_out,
    input  logic                      dut_out,
    output logic                      busy,
    output logic                      done,
    output logic [2**N_WIDTH-1:0]     resp_vec,
    output logic [SIG_WIDTH-1:0]      signature,
`ifdef GOLDEN_COMPARE_EN
    input  logic [2**N_WIDTH-1:0]     golden_vec,
    output logic                      mismatch,
    output logic [N_WIDTH:0]          mismatch_count,
`endif
    pattern_sweep_capture_if.master   rec
);

    localparam int              NUM_PAT     = 2**N_WIDTH;
    localparam int              IDX_W       = N_WIDTH + 1;
    // idx is one bit wider than a pattern so the terminal compare never wraps
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_PAT - 1);
    localparam logic [3:0]      SETTLE_LAST = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_SAMPLE,
        S_EMIT,
        S_DONE
    } state_t;

    state_t                 state_reg;
    state_t                 state_next;

    logic [IDX_W-1:0]       idx_reg;
    logic [IDX_W-1:0]       idx_next;
    logic [N_WIDTH-1:0]     pattern_reg;
    logic [3:0]             settle_cnt_reg;
    logic [NUM_PAT-1:0]     resp_reg;
    logic [NUM_PAT-1:0]     sample_hit;
    logic [SIG_WIDTH-1:0]   sig_reg;
    logic [SIG_WIDTH-1:0]   sig_next;
    logic [N_WIDTH-1:0]     rd_pattern_reg;
    logic                   rd_bit_reg;

    logic                   load_first;
    logic                   advance;
    logic                   sample_en;

    // State register
    always_ff @(posedge CK) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode and control strobes
    always_comb begin
        state_next = state_reg;
        load_first = 1'b0;
        advance    = 1'b0;
        sample_en  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_DRIVE;
                    load_first = 1'b1;
                end
            end
            S_DRIVE: begin
                busy       = 1'b1;
                state_next = (SETTLE_CYCLES > 0) ? S_SETTLE : S_SAMPLE;
            end
            S_SETTLE: begin
                busy = 1'b1;
                if (settle_cnt_reg == SETTLE_LAST) begin
                    state_next = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                busy       = 1'b1;
                sample_en  = 1'b1;
                state_next = S_EMIT;
            end
            S_EMIT: begin
                busy = 1'b1;
                if (rec.rd_ready) begin
                    if (idx_reg == LAST_IDX) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_DRIVE;
                        advance    = 1'b1;
                    end
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_next = S_DRIVE;
                    load_first = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign idx_next = idx_reg + IDX_W'(1);

    // MISR: shift left, fold in the polynomial when the MSB falls out, xor the new bit
    assign sig_next = {sig_reg[SIG_WIDTH-2:0], 1'b0}
                    ^ (sig_reg[SIG_WIDTH-1] ? POLY : '0)
                    ^ {{(SIG_WIDTH-1){1'b0}}, dut_out};

    // One-hot write strobe into the response vector for the pattern being sampled
    generate
        for (genvar gi = 0; gi < NUM_PAT; gi++) begin : g_hit
            assign sample_hit[gi] = sample_en && (idx_reg == IDX_W'(gi));
        end
    endgenerate

    // Sweep index, driven pattern and settle timer
    always_ff @(posedge CK) begin
        if (reset) begin
            idx_reg        <= '0;
            pattern_reg    <= '0;
            settle_cnt_reg <= '0;
        end else begin
            if (load_first) begin
                idx_reg     <= '0;
                pattern_reg <= '0;
            end else if (advance) begin
                idx_reg     <= idx_next;
                pattern_reg <= idx_next[N_WIDTH-1:0];
            end
            if (state_reg == S_SETTLE) begin
                settle_cnt_reg <= settle_cnt_reg + 4'd1;
            end else begin
                settle_cnt_reg <= '0;
            end
        end
    end

    // Response capture: vector, signature and the outgoing record
    always_ff @(posedge CK) begin
        if (reset) begin
            resp_reg       <= '0;
            sig_reg        <= '0;
            rd_pattern_reg <= '0;
            rd_bit_reg     <= 1'b0;
        end else if (load_first) begin
            resp_reg <= '0;
            sig_reg  <= '0;
        end else if (sample_en) begin
            resp_reg       <= (resp_reg & ~sample_hit) | (sample_hit & {NUM_PAT{dut_out}});
            sig_reg        <= sig_next;
            rd_pattern_reg <= idx_reg[N_WIDTH-1:0];
            rd_bit_reg     <= dut_out;
        end
    end

`ifdef GOLDEN_COMPARE_EN
    logic [NUM_PAT-1:0] golden_reg;
    logic               mismatch_reg;
    logic [N_WIDTH:0]   mm_count_reg;

    // Golden comparison: reference latched at start, sticky flag plus counter
    always_ff @(posedge CK) begin
        if (reset) begin
            golden_reg   <= '0;
            mismatch_reg <= 1'b0;
            mm_count_reg <= '0;
        end else if (load_first) begin
            golden_reg   <= golden_vec;
            mismatch_reg <= 1'b0;
            mm_count_reg <= '0;
        end else if (sample_en && (dut_out != golden_reg[idx_reg[N_WIDTH-1:0]])) begin
            mismatch_reg <= 1'b1;
            mm_count_reg <= mm_count_reg + (N_WIDTH+1)'(1);
        end
    end

    assign mismatch       = mismatch_reg;
    assign mismatch_count = mm_count_reg;
`endif

    assign pattern_out    = pattern_reg;
    assign resp_vec       = resp_reg;
    assign signature      = sig_reg;
    assign rec.rd_valid   = (state_reg == S_EMIT);
    assign rec.rd_pattern = rd_pattern_reg;
    assign rec.rd_bit     = rd_bit_reg;

endmodule

// File: tb/tb_pattern_sweep_capture.sv
// Bench for pattern_sweep_capture: a behavioural stand-in DUT driven from
// pattern_out, a record scoreboard fed at sweep start, and end-of-sweep checks.
module tb_pattern_sweep_capture;

    localparam int N      = 3;
    localparam int NP     = 8;
    localparam int SIGW   = 16;
    localparam int SETTLE = 1;

    logic              CK = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [0:N-1]      pattern_out;
    logic              dut_out;
    logic              busy;
    logic              done;
    logic [NP-1:0]     resp_vec;
    logic [SIGW-1:0]   signature;
`ifdef GOLDEN_COMPARE_EN
    logic [NP-1:0]     golden_vec = 8'h96;
    logic              mismatch;
    logic [N:0]        mismatch_count;
`endif

    typedef struct packed {
        logic [N-1:0] pat;
        logic         b;
    } rec_t;

    rec_t    sb_q[$];
    rec_t    mon_rec;
    int      checks = 0;
    int      failures = 0;
    int      dut_mode = 0;
    logic [N-1:0] pat_val;

    pattern_sweep_capture_if #(.N_WIDTH(N)) rec_if ();

    pattern_sweep_capture #(
        .N_WIDTH       (N),
        .SETTLE_CYCLES (SETTLE),
        .SIG_WIDTH     (SIGW),
        .POLY          (16'h1021)
    ) dut (
        .CK             (CK),
        .reset          (reset),
        .start          (start),
        .pattern_out    (pattern_out),
        .dut_out        (dut_out),
        .busy           (busy),
        .done           (done),
        .resp_vec       (resp_vec),
        .signature      (signature),
`ifdef GOLDEN_COMPARE_EN
        .golden_vec     (golden_vec),
        .mismatch       (mismatch),
        .mismatch_count (mismatch_count),
`endif
        .rec            (rec_if)
    );

    always #5 CK = ~CK;

    // Mode 0: 3-input XOR; mode 1: constant 1; mode 2: XOR with pattern 5 forced to 1
    function automatic logic model_bit(input int mode, input logic [N-1:0] p);
        case (mode)
            1:       return 1'b1;
            2:       return (p == 3'd5) ? 1'b1 : ^p;
            default: return ^p;
        endcase
    endfunction

    assign pat_val = pattern_out;
    assign dut_out = model_bit(dut_mode, pat_val);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_pattern_out", 32'(pat_val), 32'd0);
        check("rst_resp_vec",    32'(resp_vec), 32'd0);
        check("rst_signature",   32'(signature), 32'd0);
        check("rst_rd_pattern",  32'(rec_if.rd_pattern), 32'd0);
        check("rst_rd_bit",      32'(rec_if.rd_bit), 32'd0);
        check("rst_rd_valid",    32'(rec_if.rd_valid), 32'd0);
        check("rst_busy",        32'(busy), 32'd0);
        check("rst_done",        32'(done), 32'd0);
`ifdef GOLDEN_COMPARE_EN
        check("rst_mismatch",    32'(mismatch), 32'd0);
        check("rst_mm_count",    32'(mismatch_count), 32'd0);
`endif
    endtask

    // Record monitor: one line per accepted record, compared against the scoreboard
    always @(negedge CK) begin
        if (rec_if.rd_valid && rec_if.rd_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
                mon_rec = sb_q.pop_front();
                $display("record pattern=%0d bit=%0d", rec_if.rd_pattern, rec_if.rd_bit);
                check("rec_pattern", 32'(rec_if.rd_pattern), 32'(mon_rec.pat));
                check("rec_bit",     32'(rec_if.rd_bit),     32'(mon_rec.b));
            end
        end
    end

    task automatic run_sweep(input int mode, input bit stall, input int abort_at, input bit busy_start);
        int              count;
        int              exp_cycles;
        logic            bi;
        logic [NP-1:0]   e_resp;
        logic [SIGW-1:0] e_sig;

        dut_mode = mode;
        e_resp   = '0;
        e_sig    = '0;
        for (int p = 0; p < NP; p++) begin
            bi = model_bit(mode, N'(p));
            sb_q.push_back('{pat: N'(p), b: bi});
            e_resp[p] = bi;
            e_sig = {e_sig[SIGW-2:0], 1'b0} ^ (e_sig[SIGW-1] ? 16'h1021 : 16'h0000) ^ {15'd0, bi};
        end

        @(posedge CK); #1 start = 1'b1;
        @(posedge CK); #1 start = 1'b0;
        count = 0;
        check("start_resp_clr", 32'(resp_vec), 32'd0);
        check("start_sig_clr",  32'(signature), 32'd0);
        check("start_busy",     32'(busy), 32'd1);
        check("start_done_clr", 32'(done), 32'd0);

        while (done !== 1'b1 && count < 200) begin
            @(posedge CK); #1;
            count++;
            start = (busy_start && count == 10) ? 1'b1 : 1'b0;
            if (stall && count == 15) rec_if.rd_ready = 1'b0;
            if (stall && count >= 16 && count <= 20) begin
                check("stall_pattern_out", 32'(pat_val), 32'd3);
                check("stall_rd_pattern",  32'(rec_if.rd_pattern), 32'd3);
                check("stall_rd_bit",      32'(rec_if.rd_bit), 32'(model_bit(mode, 3'd3)));
                check("stall_rd_valid",    32'(rec_if.rd_valid), 32'd1);
                if (count == 20) rec_if.rd_ready = 1'b1;
            end
            if (count == abort_at) begin
                reset = 1'b1;
                @(posedge CK); #1 reset = 1'b0;
                check_reset_outputs();
                check("abort_sb_left", 32'(sb_q.size()), 32'(NP - 4));
                sb_q.delete();
                return;
            end
        end

        exp_cycles = NP * (3 + SETTLE) + (stall ? 5 : 0);
        check("sweep_cycles",   32'(count), 32'(exp_cycles));
        check("done_resp_vec",  32'(resp_vec), 32'(e_resp));
        check("done_signature", 32'(signature), 32'(e_sig));
        check("done_busy",      32'(busy), 32'd0);
        check("done_pattern",   32'(pat_val), 32'(NP - 1));
        check("done_rd_valid",  32'(rec_if.rd_valid), 32'd0);
        check("sb_empty",       32'(sb_q.size()), 32'd0);
`ifdef GOLDEN_COMPARE_EN
        check("gold_mismatch",  32'(mismatch), 32'((e_resp ^ golden_vec) != '0));
        check("gold_mm_count",  32'(mismatch_count), 32'($countones(e_resp ^ golden_vec)));
`endif
    endtask

    initial begin
        rec_if.rd_ready = 1'b1;
        reset = 1'b1;
        @(posedge CK);
        @(posedge CK); #1 reset = 1'b0;
        check_reset_outputs();

        // Plain XOR sweep, then constant-1 with a start pulse while busy
        run_sweep(0, 1'b0, -1, 1'b0);
        check("xor_resp_const", 32'(resp_vec), 32'h96);
        check("xor_sig_const",  32'(signature), 32'h0069);
        run_sweep(1, 1'b0, -1, 1'b1);
        check("one_resp_const", 32'(resp_vec), 32'hFF);
        check("one_sig_const",  32'(signature), 32'h00FF);

        // Restart from DONE with a 5-cycle logger stall on pattern 3
        run_sweep(0, 1'b1, -1, 1'b0);

        // Reset in SETTLE of pattern 4, then a full rerun
        run_sweep(0, 1'b0, 17, 1'b0);
        run_sweep(0, 1'b0, -1, 1'b0);

        // Reset and start together from DONE: reset wins
        @(posedge CK); #1 reset = 1'b1; start = 1'b1;
        @(posedge CK); #1 reset = 1'b0; start = 1'b0;
        check_reset_outputs();
        @(posedge CK); #1;
        check("rst_start_idle", 32'(busy), 32'd0);

        // XOR with pattern 5 forced high
        run_sweep(2, 1'b0, -1, 1'b0);
        check("f5_resp_const", 32'(resp_vec), 32'hB6);

        repeat (3) @(posedge CK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
